mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sequences the single shared memory port between two requesters: instruction fetch (IFU, read-only) and the load/store path driven by the execute stage (LSU, read/write).
- Uses registered-request, one-outstanding-transaction arbitration with valid/ready handshakes on every channel.
- Sits between IFU/LSU and the memory/bus bridge.
- Replaces the current combinational memory access so that memory latency can be multi-cycle.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- IFU_FUNC, 3'b010, access function code driven on the memory port for fetches (word, unsigned)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-low; rst=0 at a rising edge resets the block
- ifu_req_valid  in  1  fetch request valid
- ifu_req_ready  out  1  fetch request accepted
- ifu_addr  in  ADDR_W  fetch address
- ifu_resp_valid  out  1  fetch data valid
- ifu_resp_ready  in  1  IFU can take data
- ifu_rdata  out  DATA_W  fetch data
- lsu_req_valid  in  1  load/store request valid
- lsu_req_ready  out  1  load/store request accepted
- lsu_wen  in  1  1=store, 0=load
- lsu_func  in  3  width/sign function code (funct3)
- lsu_addr  in  ADDR_W  access address
- lsu_wdata  in  DATA_W  store data
- lsu_resp_valid  out  1  load data / store ack valid
- lsu_resp_ready  in  1  LSU can take response
- lsu_rdata  out  DATA_W  load data
- mem_req_valid  out  1  request to memory valid
- mem_req_ready  in  1  memory accepted request
- mem_wen  out  1  write enable
- mem_func  out  3  function code
- mem_addr  out  ADDR_W  address
- mem_wdata  out  DATA_W  write data
- mem_resp_valid  in  1  memory response valid (reads and writes)
- mem_resp_ready  out  1  arbiter can take response
- mem_rdata  in  DATA_W  read data
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, REQ, RESP. Registers: state, owner (IFU/LSU), last (last granted owner), and latched addr/wdata/wen/func.
- Reset (rst=0 at an edge): state=IDLE, last=LSU, so the first grant after reset goes to IFU. Latched fields=0. Reset has priority over everything.
- Output values after reset: every valid/ready output is 0 except the two IDLE-derived readies. mem_req_valid=0, ifu_resp_valid=0, lsu_resp_valid=0, mem_resp_ready=0, busy=0.
- Grant pick in IDLE is combinational:
  - Only one requester valid: grant it.
  - Both valid: grant the one that is not last (round robin).
  - Only the granted requester sees req_ready=1; the other sees 0.
  - req_ready is 0 in every non-IDLE state.
- IDLE -> REQ on the req handshake of the granted requester:
  - latch addr, wdata, wen, func; set owner and last.
  - For IFU grants: wen=0, func=IFU_FUNC, wdata=0.
- REQ:
  - mem_req_valid=1; mem_* driven only from the latched registers, stable until mem_req_ready.
  - REQ -> RESP on mem_req_ready=1.
- RESP:
  - mem_resp_ready = owner's resp_ready.
  - owner's resp_valid = mem_resp_valid; owner's rdata = mem_rdata (combinational pass-through).
  - The non-owner's resp_valid is 0.
  - RESP -> IDLE on the mem_resp_valid & mem_resp_ready handshake.
- Store ack: lsu_rdata is don't-care and is not checked.
- Latency: requester handshake in cycle N, mem_req_valid in cycle N+1 at the earliest, response same cycle as mem_resp_valid. With a zero-wait memory, a full transaction takes 3 cycles, then 1 IDLE cycle before the next grant.
- Only one transaction is outstanding. Requests arriving while busy are held by their requesters (valid must stay asserted with stable payload until ready).
- Response backpressure: the RESP state is held indefinitely while the owner's resp_ready=0.
- Reset mid-transaction (REQ or RESP): return to IDLE and drop the transaction. Any late mem_resp_valid is ignored, because mem_resp_ready=0 in IDLE.
- Unused width bits: none. Addresses are passed unmodified, and alignment is the LSU's job.

Decomposition:
- Shared package: state enum {IDLE, REQ, RESP}, owner encoding (OWN_IFU=0, OWN_LSU=1), FUNC_LW constant (3'b010).
- Sub-module rr_arb2: combinational 2-way round-robin pick. Inputs: two valids and last. Outputs: one-hot grant.
- FSM and payload latch remain in mem_arbiter.

Test Plan:
- Reset, then IFU req addr=0x80000000, zero-wait memory with rdata=0x00100073 -> mem_req_valid at cycle 1 with addr=0x80000000, wen=0, func=010; ifu_resp_valid with 0x00100073 at cycle 2; lsu_resp_valid=0 throughout.
- Both valid in IDLE with last=IFU; LSU store addr=0x80001000, wdata=0xDEADBEEF, func=010 -> LSU granted, mem_wen=1 with that addr/data. IFU then granted on the next IDLE.
- Memory holds mem_req_ready=0 for 5 cycles -> mem_* payload stable all 5 cycles, ifu_req_ready=lsu_req_ready=0, busy=1.
- LSU load in RESP with lsu_resp_ready=0 for 3 cycles while mem_resp_valid=1 -> mem_resp_ready=0, state holds; completes on the cycle lsu_resp_ready rises.
- rst=0 asserted while in RESP -> next cycle state=IDLE, all valids 0; a stray mem_resp_valid produces no ifu/lsu_resp_valid.
- Both requesters continuously valid for 6 transactions -> grants alternate IFU, LSU, IFU, LSU, IFU, LSU starting from reset.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared types and constants for the IFU/LSU memory-port arbiter.
//   state_t : arbiter FSM states (IDLE, REQ, RESP)
//   owner_t : which requester owns the transaction in flight
//   FUNC_LW : word/unsigned function code, default for instruction fetches
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

  localparam logic [2:0] FUNC_LW = 3'b010;

  // One-hot grant vector position for each owner (bit 0 IFU, bit 1 LSU).
  function automatic logic [1:0] owner_onehot(input owner_t own);
    logic [1:0] oh;
    case (own)
      OWN_IFU: oh = 2'b01;
      OWN_LSU: oh = 2'b10;
      default: oh = 2'b00;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin pick between IFU and LSU.
// Ports:
//   req_ifu, req_lsu : request valids
//   last             : owner granted most recently
//   grant[1:0]       : one-hot grant, bit 0 = IFU, bit 1 = LSU (0 when idle)
// -----------------------------------------------------------------------------
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic       req_ifu,
  input  logic       req_lsu,
  input  owner_t     last,
  output logic [1:0] grant
);

  // Round-robin pick: on contention the requester that was not served last wins.
  always_comb begin
    grant = 2'b00;
    if (req_ifu && req_lsu) begin
      if (last == OWN_LSU) begin
        grant = owner_onehot(OWN_IFU);
      end else begin
        grant = owner_onehot(OWN_LSU);
      end
    end else if (req_ifu) begin
      grant = owner_onehot(OWN_IFU);
    end else if (req_lsu) begin
      grant = owner_onehot(OWN_LSU);
    end else begin
      grant = 2'b00;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one memory port between instruction fetch (IFU, read-only) and the
// load/store unit (LSU, read/write). One transaction is outstanding at a time;
// the winning request is latched so the memory side sees a stable payload
// for as long as it takes to accept it, and the response is passed straight
// through to the owner.
// Ports:
//   clk, rst                    : clock, synchronous active-low reset
//   ifu_req_* / ifu_addr        : fetch request channel (valid/ready)
//   ifu_resp_* / ifu_rdata      : fetch response channel (valid/ready)
//   lsu_req_* / lsu_wen/func/addr/wdata : load/store request channel
//   lsu_resp_* / lsu_rdata      : load data / store ack channel
//   mem_req_* / mem_wen/func/addr/wdata : request towards memory/bus bridge
//   mem_resp_* / mem_rdata      : response from memory (reads and writes)
//   busy                        : a transaction is in flight
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int         ADDR_W   = 32,
  parameter int         DATA_W   = 32,
  parameter logic [2:0] IFU_FUNC = FUNC_LW
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  input  logic              ifu_resp_ready,
  output logic [DATA_W-1:0] ifu_rdata,

  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic              lsu_wen,
  input  logic [2:0]        lsu_func,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  output logic              lsu_resp_valid,
  input  logic              lsu_resp_ready,
  output logic [DATA_W-1:0] lsu_rdata,

  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_wen,
  output logic [2:0]        mem_func,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_resp_valid,
  output logic              mem_resp_ready,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              busy
);

  state_t            state_r;
  state_t            state_nxt_s;
  owner_t            owner_r;
  owner_t            last_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              wen_r;
  logic [2:0]        func_r;

  logic [1:0]        grant_s;
  logic              take_ifu_s;
  logic              take_lsu_s;
  logic              resp_hs_s;

  rr_arb2 u_rr_arb2 (
    .req_ifu (ifu_req_valid),
    .req_lsu (lsu_req_valid),
    .last    (last_r),
    .grant   (grant_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state plus handshake outputs. Readies exist only in IDLE and only
  // towards the granted requester; in RESP the owner's channel is wired
  // straight to memory so the response arrives in the same cycle.
  always_comb begin
    state_nxt_s    = state_r;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    mem_req_valid  = 1'b0;
    mem_resp_ready = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    take_ifu_s     = 1'b0;
    take_lsu_s     = 1'b0;
    resp_hs_s      = 1'b0;
    case (state_r)
      IDLE: begin
        ifu_req_ready = grant_s[0];
        lsu_req_ready = grant_s[1];
        if (grant_s[0] && ifu_req_valid) begin
          take_ifu_s  = 1'b1;
          state_nxt_s = REQ;
        end else if (grant_s[1] && lsu_req_valid) begin
          take_lsu_s  = 1'b1;
          state_nxt_s = REQ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = REQ;
        end
      end
      RESP: begin
        if (owner_r == OWN_IFU) begin
          mem_resp_ready = ifu_resp_ready;
          ifu_resp_valid = mem_resp_valid;
          resp_hs_s      = mem_resp_valid && ifu_resp_ready;
        end else begin
          mem_resp_ready = lsu_resp_ready;
          lsu_resp_valid = mem_resp_valid;
          resp_hs_s      = mem_resp_valid && lsu_resp_ready;
        end
        if (resp_hs_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Payload latch and ownership tracking, captured on the request handshake.
  // last starts at LSU so the first contended grant after reset goes to IFU.
  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_r <= OWN_IFU;
      last_r  <= OWN_LSU;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
      wen_r   <= 1'b0;
      func_r  <= 3'b000;
    end else if (take_ifu_s) begin
      owner_r <= OWN_IFU;
      last_r  <= OWN_IFU;
      addr_r  <= ifu_addr;
      wdata_r <= {DATA_W{1'b0}};
      wen_r   <= 1'b0;
      func_r  <= IFU_FUNC;
    end else if (take_lsu_s) begin
      owner_r <= OWN_LSU;
      last_r  <= OWN_LSU;
      addr_r  <= lsu_addr;
      wdata_r <= lsu_wdata;
      wen_r   <= lsu_wen;
      func_r  <= lsu_func;
    end else begin
      owner_r <= owner_r;
      last_r  <= last_r;
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
      wen_r   <= wen_r;
      func_r  <= func_r;
    end
  end

  // Memory payload comes only from the latch, never from requester inputs.
  assign mem_wen   = wen_r;
  assign mem_func  = func_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;

  // Read data is a pass-through; only meaningful while the owner's resp_valid is high.
  assign ifu_rdata = mem_rdata;
  assign lsu_rdata = mem_rdata;

  assign busy = (state_r != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready;
  logic [2:0]  lsu_func;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_ready;
  logic [2:0]  mem_func;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // Reference model state: who was served last (0 = IFU, 1 = LSU).
  logic m_last;

  // Random-test pending requests (held until granted).
  logic        ifu_pend, lsu_pend;
  logic [31:0] p_ia, p_la, p_lw;
  logic        p_lwen;
  logic [2:0]  p_lf;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
    .lsu_func(lsu_func), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
    .mem_func(mem_func), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifu_req_valid = 1'b0; ifu_addr = 32'h0; ifu_resp_ready = 1'b0;
    lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_func = 3'b000;
    lsu_addr = 32'h0; lsu_wdata = 32'h0; lsu_resp_ready = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'h0;
  endtask

  // One complete transaction from IDLE. Winner predicted by round robin on m_last.
  // req_wait: cycles mem_req_ready stays low; lat: cycles before mem_resp_valid;
  // bp: cycles the owner keeps resp_ready low while mem_resp_valid is high.
  task automatic run_txn(input string tag, input logic iv, input logic lv,
                         input logic [31:0] ia, input logic lwen, input logic [2:0] lf,
                         input logic [31:0] la, input logic [31:0] lwd,
                         input int req_wait, input int lat, input int bp,
                         input logic [31:0] rd, output logic win);
    logic [31:0] e_addr, e_wdata;
    logic        e_wen;
    logic [2:0]  e_func;
    logic        e_rv;
    ifu_req_valid = iv; ifu_addr = ia;
    lsu_req_valid = lv; lsu_wen = lwen; lsu_func = lf; lsu_addr = la; lsu_wdata = lwd;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
    if (iv && lv) win = ~m_last;
    else          win = lv;
    if (win == 1'b0) begin
      e_addr = ia; e_wen = 1'b0; e_func = 3'b010; e_wdata = 32'h0;
    end else begin
      e_addr = la; e_wen = lwen; e_func = lf; e_wdata = lwd;
    end
    #3;
    total++;
    if (busy !== 1'b0 || ifu_req_ready !== (win == 1'b0) || lsu_req_ready !== (win == 1'b1) ||
        mem_req_valid !== 1'b0 || mem_resp_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s grant: busy=%b ifu_rdy=%b lsu_rdy=%b mreqv=%b mrspr=%b, want busy=0 winner=%s",
               tag, busy, ifu_req_ready, lsu_req_ready, mem_req_valid, mem_resp_ready,
               win ? "LSU" : "IFU");
    end
    m_last = win;
    next_cycle();
    // Winner withdraws and scrambles its inputs: memory must see the latch only.
    if (win == 1'b0) begin
      ifu_req_valid = 1'b0; ifu_addr = $urandom;
    end else begin
      lsu_req_valid = 1'b0; lsu_addr = $urandom; lsu_wdata = $urandom; lsu_wen = ~lwen;
    end
    for (int k = 0; k <= req_wait; k++) begin
      mem_req_ready = (k == req_wait);
      #3;
      total++;
      if (mem_req_valid !== 1'b1 || mem_addr !== e_addr || mem_wen !== e_wen ||
          mem_func !== e_func || mem_wdata !== e_wdata || busy !== 1'b1 ||
          ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0 ||
          ifu_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0) begin
        bad++;
        $display("FAIL %s req[%0d]: v=%b addr=%h wen=%b func=%b wdata=%h busy=%b rdy=%b%b rv=%b%b, want v=1 addr=%h wen=%b func=%b wdata=%h busy=1 rdy=00 rv=00",
                 tag, k, mem_req_valid, mem_addr, mem_wen, mem_func, mem_wdata, busy,
                 ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid,
                 e_addr, e_wen, e_func, e_wdata);
      end
      next_cycle();
    end
    mem_req_ready = 1'b0;
    for (int k = 0; k <= lat + bp; k++) begin
      e_rv = (k >= lat);
      mem_resp_valid = e_rv;
      mem_rdata = e_rv ? rd : $urandom;
      if (win == 1'b0) begin
        ifu_resp_ready = (k == lat + bp); lsu_resp_ready = 1'($urandom_range(0, 1));
      end else begin
        lsu_resp_ready = (k == lat + bp); ifu_resp_ready = 1'($urandom_range(0, 1));
      end
      #3;
      total++;
      if (ifu_resp_valid !== (win == 1'b0 && e_rv) || lsu_resp_valid !== (win == 1'b1 && e_rv) ||
          mem_resp_ready !== (k == lat + bp) || busy !== 1'b1 || mem_req_valid !== 1'b0 ||
          ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0) begin
        bad++;
        $display("FAIL %s resp[%0d]: ifu_rv=%b lsu_rv=%b mrspr=%b busy=%b mreqv=%b rdy=%b%b, want owner=%s rv=%b mrspr=%b busy=1",
                 tag, k, ifu_resp_valid, lsu_resp_valid, mem_resp_ready, busy, mem_req_valid,
                 ifu_req_ready, lsu_req_ready, win ? "LSU" : "IFU", e_rv, (k == lat + bp));
      end
      if (e_rv && (win == 1'b0 || !e_wen)) begin
        total++;
        if ((win == 1'b0 ? ifu_rdata : lsu_rdata) !== rd) begin
          bad++;
          $display("FAIL %s rdata[%0d]: got %h want %h", tag, k,
                   (win == 1'b0 ? ifu_rdata : lsu_rdata), rd);
        end
      end
      next_cycle();
    end
    mem_resp_valid = 1'b0; ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    next_cycle();
    next_cycle();
    #3;
    total++;
    if (mem_req_valid !== 1'b0 || ifu_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0 ||
        mem_resp_ready !== 1'b0 || busy !== 1'b0 || mem_addr !== 32'h0 ||
        mem_wdata !== 32'h0 || mem_wen !== 1'b0 || mem_func !== 3'b000) begin
      bad++;
      $display("FAIL reset_outputs: mreqv=%b rv=%b%b mrspr=%b busy=%b addr=%h wdata=%h wen=%b func=%b, want all 0",
               mem_req_valid, ifu_resp_valid, lsu_resp_valid, mem_resp_ready, busy,
               mem_addr, mem_wdata, mem_wen, mem_func);
    end
    // Contention while still in reset: last=LSU so IFU is the one offered ready.
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    #1;
    total++;
    if (ifu_req_ready !== 1'b1 || lsu_req_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_first_grant: ifu_rdy=%b lsu_rdy=%b, want 1 0", ifu_req_ready, lsu_req_ready);
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    next_cycle();
    rst = 1'b1;
    m_last = 1'b1;
  endtask

  task automatic test_ifu_fetch();
    logic w;
    run_txn("ifu_fetch", 1'b1, 1'b0, 32'h8000_0000, 1'b0, 3'b000, 32'h0, 32'h0,
            0, 0, 0, 32'h0010_0073, w);
  endtask

  task automatic test_rr_store();
    logic w;
    // Last grant was IFU, so the LSU store wins the contention.
    run_txn("rr_store", 1'b1, 1'b1, 32'h8000_0004, 1'b1, 3'b010, 32'h8000_1000, 32'hDEAD_BEEF,
            0, 0, 0, 32'h0, w);
    run_txn("rr_ifu_next", 1'b1, 1'b0, 32'h8000_0004, 1'b0, 3'b000, 32'h0, 32'h0,
            0, 0, 0, 32'h1234_5678, w);
  endtask

  task automatic test_req_stall();
    logic w;
    run_txn("req_stall", 1'b0, 1'b1, 32'h0, 1'b1, 3'b001, 32'h8000_2002, 32'hCAFE_F00D,
            5, 1, 0, 32'h0, w);
  endtask

  task automatic test_resp_backpressure();
    logic w;
    run_txn("resp_bp", 1'b0, 1'b1, 32'h0, 1'b0, 3'b100, 32'h8000_3001, 32'h0,
            0, 0, 3, 32'hA5A5_5A5A, w);
  endtask

  task automatic test_reset_mid();
    logic w;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0040;
    next_cycle();
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    next_cycle();
    mem_req_ready = 1'b0;
    #3;
    total++;
    if (busy !== 1'b1 || ifu_resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_pre: busy=%b ifu_rv=%b, want 1 0", busy, ifu_resp_valid);
    end
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    m_last = 1'b1;
    mem_resp_valid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    ifu_resp_ready = 1'b1; lsu_resp_ready = 1'b1;
    #3;
    total++;
    if (busy !== 1'b0 || ifu_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0 ||
        mem_resp_ready !== 1'b0 || mem_req_valid !== 1'b0 || mem_addr !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid_post: busy=%b rv=%b%b mrspr=%b mreqv=%b addr=%h, want all 0",
               busy, ifu_resp_valid, lsu_resp_valid, mem_resp_ready, mem_req_valid, mem_addr);
    end
    mem_resp_valid = 1'b0; ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
    next_cycle();
    // After reset the contended grant must go to IFU again.
    run_txn("reset_mid_after", 1'b1, 1'b1, 32'h8000_0080, 1'b0, 3'b010, 32'h8000_4000, 32'h0,
            0, 0, 0, 32'h0000_0013, w);
    total++;
    if (w !== 1'b0 || ifu_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_rr: ifu valid still %b after its turn, want IFU served first", ifu_req_valid);
    end
    lsu_req_valid = 1'b0;
  endtask

  task automatic test_alternate();
    logic w;
    test_reset();
    for (int i = 0; i < 6; i++) begin
      run_txn($sformatf("alternate%0d", i), 1'b1, 1'b1, 32'h8000_0100, 1'b1, 3'b010,
              32'h8000_5000, 32'h0BAD_F00D, 0, 0, 0, 32'h0000_1000 + i, w);
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
  endtask

  task automatic test_random();
    logic w;
    ifu_pend = 1'b0; lsu_pend = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!ifu_pend && $urandom_range(0, 2) != 0) begin
        ifu_pend = 1'b1; p_ia = $urandom;
      end
      if (!lsu_pend && $urandom_range(0, 2) != 0) begin
        lsu_pend = 1'b1; p_la = $urandom; p_lw = $urandom;
        p_lwen = 1'($urandom_range(0, 1)); p_lf = 3'($urandom_range(0, 7));
      end
      if (!ifu_pend && !lsu_pend) begin
        ifu_pend = 1'b1; p_ia = $urandom;
      end
      run_txn($sformatf("random%0d", i), ifu_pend, lsu_pend, p_ia, p_lwen, p_lf, p_la, p_lw,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), $urandom, w);
      if (w == 1'b0) ifu_pend = 1'b0;
      else           lsu_pend = 1'b0;
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
  endtask

  initial begin
    m_last = 1'b1;
    p_lwen = 1'b0; p_lf = 3'b000; p_la = 32'h0; p_lw = 32'h0; p_ia = 32'h0;
    test_reset();
    test_ifu_fetch();
    test_rr_store();
    test_req_stall();
    test_resp_backpressure();
    test_reset_mid();
    test_alternate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
